// File: rtl/skip_ring_seq_if.sv
// Control/status bundle for skip_ring_seq: settings, strobes and the registered
// enable/status outputs.
interface skip_ring_seq_if #(
  parameter int unsigned LEN = 16,
  parameter int unsigned RW  = 5,
  parameter int unsigned BW  = 16
);
  logic           E;
  logic [1:0]     MODE;
  logic [LEN-1:0] MASK;
  logic [RW-1:0]  RATIO;
  logic           LOAD;
  logic [BW-1:0]  BURST_N;
  logic           GO;
  logic           oCE;
  logic           oB0;
  logic           BUSY;
  logic           DONE;
  logic           PEND;

  modport master (
    output E, MODE, MASK, RATIO, LOAD, BURST_N, GO,
    input  oCE, oB0, BUSY, DONE, PEND
  );

  modport slave (
    input  E, MODE, MASK, RATIO, LOAD, BURST_N, GO,
    output oCE, oB0, BUSY, DONE, PEND
  );
endinterface

// File: rtl/skip_ring_seq.sv
// Clock-skip sequencer: mask / ratio / burst / bypass enable generation with
// frame-aligned double-buffered settings. SKIP_RING_CLKGATE_EN adds a gated clock oCLK.
module skip_ring_seq #(
  parameter int unsigned LEN = 16,
  parameter int unsigned RW  = 5,
  parameter int unsigned BW  = 16
) (
  input  logic            CLK,
  input  logic            RST,
  skip_ring_seq_if.slave  bus
`ifdef SKIP_RING_CLKGATE_EN
  ,
  output logic            oCLK
`endif
);

  localparam int unsigned SW = RW + 1;
  localparam logic [SW-1:0] LEN_W = SW'(LEN);
  localparam logic [1:0] M_MASK  = 2'd0;
  localparam logic [1:0] M_RATIO = 2'd1;
  localparam logic [1:0] M_BURST = 2'd2;

  typedef enum logic [1:0] {B_IDLE, B_RUN, B_FIN} bst_t;

  logic [LEN-1:0] ptr;
  logic [RW-1:0]  acc;
  logic [1:0]     mode_act, mode_sh;
  logic [LEN-1:0] mask_act, mask_sh;
  logic [RW-1:0]  ratio_act, ratio_sh;
  logic           pend;
  bst_t           bst;
  logic [BW-1:0]  cnt;
  logic           oce, ob0, busy, done;

  logic [SW-1:0]  ratio_c, sum;
  logic           pass_r, wrap, apply, oce_b, oce_n, done_n;
  logic [RW-1:0]  acc_step;
  bst_t           bst_n;
  logic [BW-1:0]  cnt_n;

  // Slot decision for the current frame position plus burst next-state.
  always_comb begin
    ratio_c  = ({1'b0, ratio_act} > LEN_W) ? LEN_W : {1'b0, ratio_act};
    sum      = {1'b0, acc} + ratio_c;
    pass_r   = (sum >= LEN_W);
    acc_step = pass_r ? RW'(sum - LEN_W) : RW'(sum);
    wrap     = bus.E && ptr[LEN-1];
    apply    = wrap && pend;
    bst_n    = bst;
    cnt_n    = cnt;
    done_n   = 1'b0;
    oce_b    = 1'b0;

    if (mode_act == M_BURST) begin
      case (bst)
        B_IDLE: begin
          if (bus.GO) begin
            if (bus.BURST_N != '0) begin
              bst_n = B_RUN;
              cnt_n = bus.BURST_N;
            end else begin
              bst_n = B_FIN;
            end
          end
        end
        B_RUN: begin
          oce_b = 1'b1;
          cnt_n = cnt - BW'(1);
          if (cnt_n == '0) bst_n = B_FIN;
        end
        B_FIN: begin
          done_n = 1'b1;
          bst_n  = B_IDLE;
        end
        default: bst_n = B_IDLE;
      endcase
    end

    // Leaving burst mode at a frame boundary abandons any burst silently.
    if (apply && (mode_sh != M_BURST)) begin
      bst_n  = B_IDLE;
      cnt_n  = '0;
      done_n = 1'b0;
    end

    case (mode_act)
      M_MASK:  oce_n = ~|(mask_act & ptr);
      M_RATIO: oce_n = pass_r;
      M_BURST: oce_n = oce_b;
      default: oce_n = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr       <= LEN'(1);
      acc       <= '0;
      mode_act  <= M_MASK;
      mask_act  <= '0;
      ratio_act <= '0;
      mode_sh   <= M_MASK;
      mask_sh   <= '0;
      ratio_sh  <= '0;
      pend      <= 1'b0;
      bst       <= B_IDLE;
      cnt       <= '0;
      oce       <= 1'b1;
      ob0       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (bus.LOAD) begin
        mode_sh  <= bus.MODE;
        mask_sh  <= bus.MASK;
        ratio_sh <= bus.RATIO;
        pend     <= 1'b1;
      end else if (apply) begin
        pend     <= 1'b0;
      end

      ob0 <= ptr[0];

      if (bus.E) begin
        ptr  <= {ptr[LEN-2:0], ptr[LEN-1]};
        oce  <= oce_n;
        bst  <= bst_n;
        cnt  <= cnt_n;
        busy <= (bst_n == B_RUN);
        done <= done_n;
        if (mode_act == M_RATIO) acc <= acc_step;
        if (apply) begin
          mode_act  <= mode_sh;
          mask_act  <= mask_sh;
          ratio_act <= ratio_sh;
          acc       <= '0;
        end
      end else begin
        oce  <= 1'b1;
        done <= 1'b0;
      end
    end
  end

  assign bus.oCE  = oce;
  assign bus.oB0  = ob0;
  assign bus.BUSY = busy;
  assign bus.DONE = done;
  assign bus.PEND = pend;

`ifdef SKIP_RING_CLKGATE_EN
  logic ce_lat;

  // Enable latch is transparent in the low phase so oCLK cannot glitch.
  always_latch begin
    if (!CLK) ce_lat = RST ? 1'b1 : oce;
  end

  assign oCLK = CLK & ce_lat;
`endif

endmodule

// File: tb/tb_skip_ring_seq.sv
// Scoreboard bench for skip_ring_seq: driver queues hand-derived expectations,
// a negedge monitor pops and compares {oCE,oB0,BUSY,DONE,PEND}.
module tb_skip_ring_seq;

  localparam logic [15:0] ALL1   = 16'hFFFF;
  localparam logic [15:0] ALL0   = 16'h0000;
  localparam logic [15:0] PAT_M  = 16'h7FFE;  // MASK 8001 -> slots 0 and 15 skipped
  localparam logic [15:0] PAT_R5 = 16'h9248;  // ratio 5/16 passes slots 3,6,9,12,15

  logic clk;
  logic rst;

  skip_ring_seq_if #(.LEN(16), .RW(5), .BW(16)) bus ();

  skip_ring_seq #(.LEN(16), .RW(5), .BW(16)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  string      q_name[$];
  logic [4:0] q_val[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         cur         = 0;
  int         last_slot   = 0;
  logic       pend_m      = 1'b0;

  always @(negedge clk) begin
    if (q_val.size() > 0) begin
      string      nm;
      logic [4:0] exp_v;
      logic [4:0] act_v;
      nm    = q_name.pop_front();
      exp_v = q_val.pop_front();
      act_v = {bus.oCE, bus.oB0, bus.BUSY, bus.DONE, bus.PEND};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL %s @%0t: got %b want %b (oCE,oB0,BUSY,DONE,PEND)", nm, $time, act_v, exp_v);
      end
    end
  end

  // One clock; pat[slot]=1 means that slot is expected to pass.
  task automatic cyc(input string nm, input logic [15:0] pat, input logic busy_e, input logic done_e);
    logic oce_e, ob0_e;
    @(posedge clk);
    if (rst) begin
      cur    = 0;
      pend_m = 1'b0;
      oce_e  = 1'b1;
      ob0_e  = 1'b1;
    end else if (bus.E) begin
      last_slot = cur;
      cur       = (cur + 1) % 16;
      oce_e     = pat[last_slot];
      ob0_e     = (last_slot == 0);
      if (bus.LOAD) pend_m = 1'b1;
      else if (last_slot == 15) pend_m = 1'b0;
    end else begin
      oce_e = 1'b1;
      ob0_e = (cur == 0);
      if (bus.LOAD) pend_m = 1'b1;
    end
    #1;
    q_name.push_back(nm);
    q_val.push_back({oce_e, ob0_e, busy_e, done_e, pend_m});
  endtask

  task automatic run_to_wrap(input string nm, input logic [15:0] pat);
    int guard = 0;
    do begin
      cyc(nm, pat, 1'b0, 1'b0);
      guard++;
    end while (last_slot != 15 && guard < 17);
    if (last_slot != 15) begin
      miscompares++;
      $display("FAIL %s: frame wrap not reached, slot %0d want 15", nm, last_slot);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.E       = 1'b1;
    bus.MODE    = 2'd0;
    bus.MASK    = '0;
    bus.RATIO   = '0;
    bus.LOAD    = 1'b0;
    bus.BURST_N = '0;
    bus.GO      = 1'b0;

    // T1: reset values, then free-running frame marker with period 16
    cyc("t1_rst", ALL1, 1'b0, 1'b0);
    cyc("t1_rst", ALL1, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (32) cyc("t1_free", ALL1, 1'b0, 1'b0);

    // T2: mid-frame mask load stays pending until the wrap
    repeat (5) cyc("t2_pre", ALL1, 1'b0, 1'b0);
    bus.MODE = 2'd0; bus.MASK = 16'h8001; bus.LOAD = 1'b1;
    cyc("t2_load", ALL1, 1'b0, 1'b0);
    bus.LOAD = 1'b0;
    run_to_wrap("t2_pend", ALL1);
    repeat (32) cyc("t2_mask", PAT_M, 1'b0, 1'b0);

    // T3: ratio 5/16 over four frames
    bus.MODE = 2'd1; bus.RATIO = 5'd5; bus.LOAD = 1'b1;
    cyc("t3_load", PAT_M, 1'b0, 1'b0);
    bus.LOAD = 1'b0;
    run_to_wrap("t3_pend", PAT_M);
    repeat (64) cyc("t3_r5", PAT_R5, 1'b0, 1'b0);

    // T5: freeze in ratio mode, pattern resumes where it left off
    repeat (4) cyc("t5_pre", PAT_R5, 1'b0, 1'b0);
    bus.E = 1'b0;
    repeat (5) cyc("t5_frz", PAT_R5, 1'b0, 1'b0);
    bus.E = 1'b1;
    repeat (28) cyc("t5_res", PAT_R5, 1'b0, 1'b0);

    // T3: ratio above LEN passes every cycle
    bus.RATIO = 5'd31; bus.LOAD = 1'b1;
    cyc("t3_r31_load", PAT_R5, 1'b0, 1'b0);
    bus.LOAD = 1'b0;
    run_to_wrap("t3_r31_pend", PAT_R5);
    repeat (32) cyc("t3_r31", ALL1, 1'b0, 1'b0);

    // T4: burst mode
    bus.MODE = 2'd2; bus.LOAD = 1'b1;
    cyc("t4_load", ALL1, 1'b0, 1'b0);
    bus.LOAD = 1'b0;
    run_to_wrap("t4_pend", ALL1);
    repeat (3) cyc("t4_idle", ALL0, 1'b0, 1'b0);
    bus.BURST_N = 16'd3; bus.GO = 1'b1;
    cyc("t4_go", ALL0, 1'b1, 1'b0);
    bus.GO = 1'b0;
    cyc("t4_run1", ALL1, 1'b1, 1'b0);
    cyc("t4_run2", ALL1, 1'b1, 1'b0);
    cyc("t4_run3", ALL1, 1'b0, 1'b0);
    cyc("t4_done", ALL0, 1'b0, 1'b1);
    cyc("t4_post", ALL0, 1'b0, 1'b0);

    bus.BURST_N = 16'd3; bus.GO = 1'b1;
    cyc("t4_go2", ALL0, 1'b1, 1'b0);
    bus.BURST_N = 16'd5;
    cyc("t4_goign", ALL1, 1'b1, 1'b0);
    bus.GO = 1'b0;
    cyc("t4_run2b", ALL1, 1'b1, 1'b0);
    cyc("t4_run3b", ALL1, 1'b0, 1'b0);
    cyc("t4_done2", ALL0, 1'b0, 1'b1);
    cyc("t4_post2", ALL0, 1'b0, 1'b0);

    bus.BURST_N = 16'd0; bus.GO = 1'b1;
    cyc("t4_go0", ALL0, 1'b0, 1'b0);
    bus.GO = 1'b0;
    cyc("t4_done0", ALL0, 1'b0, 1'b1);
    cyc("t4_post0", ALL0, 1'b0, 1'b0);

    // T6: reset during a burst with a pending all-skip mask
    for (int i = 0; i < 16 && cur != 2; i++) cyc("t6_align", ALL0, 1'b0, 1'b0);
    bus.BURST_N = 16'd4; bus.GO = 1'b1;
    cyc("t6_go", ALL0, 1'b1, 1'b0);
    bus.GO = 1'b0;
    bus.MODE = 2'd0; bus.MASK = 16'hFFFF; bus.LOAD = 1'b1;
    cyc("t6_load", ALL1, 1'b1, 1'b0);
    bus.LOAD = 1'b0;
    rst = 1'b1;
    cyc("t6_rst", ALL1, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (20) cyc("t6_after", ALL1, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (q_val.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q_val.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
